// File: rtl/filter_pkg.sv
// Shared width, coefficient-select and FSM types for the biquad voice scheduler.
package filter_pkg;
    localparam int W = 16;

    typedef enum logic [2:0] {
        A0 = 3'd0, A1 = 3'd1, A2 = 3'd2, B0 = 3'd3, B1 = 3'd4, B2 = 3'd5
    } coef_sel_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0, MAC = 2'd1, SCALE = 2'd2, DONE = 2'd3
    } state_e;
endpackage

// File: rtl/q16_mul.sv
// Unsigned W x W multiply returning the upper W bits of the 2W-bit product.
module q16_mul #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] p
);
    assign p = W'(({{W{1'b0}}, a} * {{W{1'b0}}, b}) >> W);
endmodule

// File: rtl/biquad_voice_sched.sv
// Round-robin scheduler time-sharing one multiplier across NVOICE biquad voices;
// each sample takes five MAC steps plus one scale step.
module biquad_voice_sched #(
    parameter int NVOICE = 4,
    parameter int W = filter_pkg::W,
    localparam int VW = $clog2(NVOICE)
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Enable,
    input  logic [NVOICE-1:0]   req,
    input  logic [NVOICE*W-1:0] x,
    input  logic                cfg_we,
    input  logic [VW-1:0]       cfg_voice,
    input  logic [2:0]          cfg_sel,
    input  logic [W-1:0]        cfg_data,
    output logic [NVOICE-1:0]   gnt,
    output logic [W-1:0]        y,
    output logic                y_valid,
    output logic [VW-1:0]       y_voice,
    output logic                busy
);
    import filter_pkg::*;

    logic [NVOICE-1:0][5:0][W-1:0] coef;
    logic [NVOICE-1:0][W-1:0]      hx1, hx2, hy1, hy2;
    logic [5:0][W-1:0]             kc;
    logic [W-1:0]                  sx, sx1, sx2, sy1, sy2, acc;
    logic [VW-1:0]                 cur, ptr, gv;
    logic [2:0]                    step;
    logic [NVOICE-1:0]             elig;
    logic                          grant;
    logic [W-1:0]                  mul_a, mul_b, mul_p;
    state_e                        state, state_nx;

    q16_mul #(.W(W)) u_mul (.a(mul_a), .b(mul_b), .p(mul_p));

    always_comb begin
        state_nx = state;
        grant    = 1'b0;
        gv       = '0;
        gnt      = '0;
        elig     = req;
        // The finishing voice is not re-granted in its own DONE cycle, so its
        // history snapshot never races the history write-back.
        if (state == DONE) elig[cur] = 1'b0;
        if ((state == IDLE || state == DONE) && Enable && !Reset) begin
            for (int i = NVOICE - 1; i >= 0; i--) begin
                if (elig[ptr + VW'(i)]) begin
                    grant = 1'b1;
                    gv    = ptr + VW'(i);
                end
            end
        end
        if (grant) gnt[gv] = 1'b1;
        case (state)
            IDLE:    if (grant) state_nx = MAC;
            MAC:     if (step == 3'd4) state_nx = SCALE;
            SCALE:   state_nx = DONE;
            DONE:    state_nx = grant ? MAC : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy    = !Reset && (grant || state != IDLE);
    assign y_valid = !Reset && state == DONE;

    always_comb begin
        mul_a = kc[B0];
        mul_b = sx;
        case (step)
            3'd1:    begin mul_a = kc[B1]; mul_b = sx1; end
            3'd2:    begin mul_a = kc[B2]; mul_b = sx2; end
            3'd3:    begin mul_a = kc[A1]; mul_b = sy1; end
            3'd4:    begin mul_a = kc[A2]; mul_b = sy2; end
            default: ;
        endcase
        if (state == SCALE) begin
            mul_a = kc[A0];
            mul_b = acc;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= IDLE;
            ptr     <= '0;
            cur     <= '0;
            step    <= '0;
            acc     <= '0;
            y       <= '0;
            y_voice <= '0;
            kc      <= '0;
            sx      <= '0;
            sx1     <= '0;
            sx2     <= '0;
            sy1     <= '0;
            sy2     <= '0;
            hx1     <= '0;
            hx2     <= '0;
            hy1     <= '0;
            hy2     <= '0;
            coef    <= '0;
            for (int v = 0; v < NVOICE; v++) begin
                coef[v][A0] <= '1;
                coef[v][B0] <= '1;
            end
        end else begin
            state <= state_nx;
            if (cfg_we && cfg_sel <= 3'd5) coef[cfg_voice][cfg_sel] <= cfg_data;
            if (grant) begin
                cur  <= gv;
                ptr  <= gv + VW'(1);
                step <= '0;
                acc  <= '0;
                kc   <= coef[gv];
                sx   <= x[gv*W +: W];
                sx1  <= hx1[gv];
                sx2  <= hx2[gv];
                sy1  <= hy1[gv];
                sy2  <= hy2[gv];
            end else if (state == MAC) begin
                acc  <= acc + mul_p;
                step <= step + 3'd1;
            end else if (state == SCALE) begin
                y       <= mul_p;
                y_voice <= cur;
            end
            // Old cur/sx are read here even when a new grant lands on this edge.
            if (state == DONE) begin
                hx2[cur] <= hx1[cur];
                hx1[cur] <= sx;
                hy2[cur] <= hy1[cur];
                hy1[cur] <= y;
            end
        end
    end
endmodule

// File: tb/tb_biquad_voice_sched.sv
// Bench for biquad_voice_sched: directed vector table, hand sequences, and a
// randomized run against a transaction-level scheduler/filter model.
module tb_biquad_voice_sched;
    localparam int NV = 4;

    logic          Clk, Reset, Enable;
    logic [NV-1:0] req;
    logic [NV*16-1:0] x;
    logic          cfg_we;
    logic [1:0]    cfg_voice;
    logic [2:0]    cfg_sel;
    logic [15:0]   cfg_data;
    logic [NV-1:0] gnt;
    logic [15:0]   y;
    logic          y_valid;
    logic [1:0]    y_voice;
    logic          busy;

    biquad_voice_sched #(.NVOICE(NV), .W(16)) dut (
        .Clk(Clk), .Reset(Reset), .Enable(Enable), .req(req), .x(x),
        .cfg_we(cfg_we), .cfg_voice(cfg_voice), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
        .gnt(gnt), .y(y), .y_valid(y_valid), .y_voice(y_voice), .busy(busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int ncmp = 0;
    int nerr = 0;

    function automatic void check(input string nm, input longint act, input longint exp);
        ncmp++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic logic [15:0] hi(input logic [15:0] a, input logic [15:0] b);
        longint p;
        p = longint'(a) * longint'(b);
        return 16'(p >> 16);
    endfunction

    task automatic do_reset();
        Reset = 1'b1; req = '0; x = '0; cfg_we = 1'b0; Enable = 1'b1;
        cfg_voice = '0; cfg_sel = '0; cfg_data = '0;
        @(posedge Clk); @(posedge Clk); #1;
        Reset = 1'b0;
    endtask

    task automatic cfg_write(input int v, input int sel, input logic [15:0] d);
        cfg_we = 1'b1; cfg_voice = 2'(v); cfg_sel = 3'(sel); cfg_data = d;
        @(posedge Clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic run_sample(input string nm, input int v, input logic [15:0] xv,
                              input logic [15:0] ey);
        int t0;
        bit got;
        t0 = -1; got = 1'b0;
        req[v] = 1'b1;
        x[v*16 +: 16] = xv;
        for (int k = 0; k < 30 && !got; k++) begin
            @(negedge Clk);
            if (t0 < 0 && gnt[v]) t0 = cyc;
            if (y_valid) begin
                got = 1'b1;
                check({nm, " latency"}, cyc - t0, 7);
                check({nm, " y"}, y, ey);
                check({nm, " y_voice"}, y_voice, v);
            end
            @(posedge Clk); #1;
            if (t0 >= 0) req[v] = 1'b0;
        end
        check({nm, " completed"}, got, 1);
    endtask

    typedef struct {
        int          voice;
        logic [15:0] xin;
        logic [15:0] ey;
    } vec_t;
    vec_t tbl[6];

    // Transaction-level reference: filter value computed at grant time.
    logic [15:0] mc [NV][6];
    logic [15:0] mx1[NV], mx2[NV], my1[NV], my2[NV];
    int          mptr, mcur, mdone;
    bit          minfl;
    logic [15:0] pend_x, pend_y, last_y;
    int          last_yv;

    function automatic void model_reset();
        for (int v = 0; v < NV; v++) begin
            for (int s = 0; s < 6; s++) mc[v][s] = 16'h0;
            mc[v][0] = 16'hFFFF;
            mc[v][3] = 16'hFFFF;
            mx1[v] = 0; mx2[v] = 0; my1[v] = 0; my2[v] = 0;
        end
        mptr = 0; mcur = 0; mdone = 0; minfl = 0;
        pend_x = 0; pend_y = 0; last_y = 0; last_yv = 0;
    endfunction

    function automatic logic [15:0] model_y(input int v, input logic [15:0] xv);
        int s;
        s = int'(hi(mc[v][3], xv)) + int'(hi(mc[v][4], mx1[v])) + int'(hi(mc[v][5], mx2[v]))
          + int'(hi(mc[v][1], my1[v])) + int'(hi(mc[v][2], my2[v]));
        return hi(mc[v][0], 16'(s));
    endfunction

    function automatic void model_step();
        bit          ev;
        int          eg;
        logic [3:0]  egnt;
        ev = minfl && (cyc == mdone);
        eg = -1;
        if ((!minfl || ev) && Enable) begin
            for (int k = 0; k < NV && eg < 0; k++) begin
                int v;
                v = (mptr + k) % NV;
                if (req[v] && !(ev && v == mcur)) eg = v;
            end
        end
        egnt = (eg >= 0) ? 4'(1 << eg) : 4'h0;
        check("rnd gnt", gnt, egnt);
        check("rnd busy", busy, (eg >= 0) || minfl);
        check("rnd y_valid", y_valid, ev);
        if (ev) begin
            check("rnd y", y, pend_y);
            check("rnd y_voice", y_voice, mcur);
            mx2[mcur] = mx1[mcur]; mx1[mcur] = pend_x;
            my2[mcur] = my1[mcur]; my1[mcur] = pend_y;
            last_y = pend_y; last_yv = mcur; minfl = 0;
        end else begin
            check("rnd y hold", y, last_y);
            check("rnd y_voice hold", y_voice, last_yv);
        end
        if (eg >= 0) begin
            pend_x = x[eg*16 +: 16];
            pend_y = model_y(eg, pend_x);
            mcur = eg; mptr = (eg + 1) % NV; minfl = 1; mdone = cyc + 7;
        end
        if (cfg_we && cfg_sel < 3'd6) mc[cfg_voice][cfg_sel] = cfg_data;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int          t0, nv, ng;
    logic [3:0]  g;
    int          gq[$], tq[$];
    bit          got;

    initial begin
        tbl[0] = '{0, 16'h8000, 16'h7FFE};
        tbl[1] = '{1, 16'hFFFF, 16'hFFFD};
        tbl[2] = '{2, 16'h1000, 16'h0FFE};
        tbl[3] = '{3, 16'h4000, 16'h3FFE};
        tbl[4] = '{0, 16'h0001, 16'h0000};
        tbl[5] = '{1, 16'h0000, 16'h0000};

        Reset = 1'b1; req = '1; x = '0; Enable = 1'b1; cfg_we = 1'b0;
        cfg_voice = '0; cfg_sel = '0; cfg_data = '0;
        @(negedge Clk);
        check("reset gnt", gnt, 0);
        check("reset busy", busy, 0);
        do_reset();
        @(negedge Clk);
        check("post-reset gnt", gnt, 0);
        check("post-reset busy", busy, 0);
        check("post-reset y_valid", y_valid, 0);
        check("post-reset y", y, 0);
        check("post-reset y_voice", y_voice, 0);
        @(posedge Clk); #1;

        for (int i = 0; i < 6; i++)
            run_sample($sformatf("vec%0d", i), tbl[i].voice, tbl[i].xin, tbl[i].ey);

        // All voices requesting from the first cycle: strict rotation, 7 apart.
        do_reset();
        req = '1; x = '0;
        t0 = cyc;
        gq.delete(); tq.delete();
        for (int k = 0; k < 40; k++) begin
            @(negedge Clk);
            g = gnt;
            for (int v = 0; v < NV; v++) if (g[v]) begin gq.push_back(v); tq.push_back(cyc); end
            @(posedge Clk); #1;
            req = req & ~g;
        end
        check("rr grant count", gq.size(), 4);
        if (gq.size() > 0) check("rr first grant cycle", tq[0], t0);
        for (int i = 0; i < gq.size() && i < 4; i++) begin
            check($sformatf("rr order %0d", i), gq[i], i);
            check($sformatf("rr spacing %0d", i), tq[i] - tq[0], 7 * i);
        end

        // Voice 2 with b1 only: output reflects the previous input.
        do_reset();
        cfg_write(2, 3, 16'h0000);
        cfg_write(2, 4, 16'h8000);
        cfg_write(2, 0, 16'hFFFF);
        run_sample("v2 first", 2, 16'h4000, 16'h0000);
        run_sample("v2 second", 2, 16'h0000, 16'h1FFF);

        // Reset mid-computation aborts it.
        do_reset();
        req[1] = 1'b1; x[16 +: 16] = 16'h8000;
        t0 = -1;
        for (int k = 0; k < 10 && t0 < 0; k++) begin
            @(negedge Clk);
            if (gnt[1]) t0 = cyc;
            @(posedge Clk); #1;
        end
        check("abort granted", t0 >= 0, 1);
        req[1] = 1'b0;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        Reset = 1'b1;
        nv = 0;
        @(negedge Clk);
        if (y_valid) nv++;
        @(posedge Clk); #1;
        Reset = 1'b0;
        @(negedge Clk);
        check("abort busy", busy, 0);
        for (int k = 0; k < 12; k++) begin
            if (y_valid) nv++;
            @(posedge Clk); #1;
            @(negedge Clk);
        end
        check("abort no y_valid", nv, 0);
        @(posedge Clk); #1;
        cfg_write(1, 3, 16'h0000);
        cfg_write(1, 4, 16'hFFFF);
        run_sample("abort history", 1, 16'h0000, 16'h0000);

        // Enable low blocks grants; raising it grants in the same cycle.
        do_reset();
        Enable = 1'b0;
        req[1] = 1'b1; x[16 +: 16] = 16'h1234;
        ng = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge Clk);
            if (gnt != 0 || busy) ng++;
            @(posedge Clk); #1;
        end
        check("enable low no grant", ng, 0);
        Enable = 1'b1;
        @(negedge Clk);
        check("enable high gnt", gnt, 4'b0010);
        @(posedge Clk); #1;
        req[1] = 1'b0;
        repeat (10) @(posedge Clk);
        #1;

        // Coefficient write to the in-flight voice only affects the next sample.
        do_reset();
        req[0] = 1'b1; x[0 +: 16] = 16'h8000;
        t0 = -1;
        for (int k = 0; k < 10 && t0 < 0; k++) begin
            @(negedge Clk);
            if (gnt[0]) t0 = cyc;
            @(posedge Clk); #1;
        end
        req[0] = 1'b0;
        cfg_write(0, 3, 16'h0000);
        got = 1'b0;
        for (int k = 0; k < 12 && !got; k++) begin
            @(negedge Clk);
            if (y_valid) begin
                got = 1'b1;
                check("cfg inflight latency", cyc - t0, 7);
                check("cfg inflight y", y, 16'h7FFE);
            end
            @(posedge Clk); #1;
        end
        check("cfg inflight completed", got, 1);
        run_sample("cfg next sample", 0, 16'h8000, 16'h0000);

        // Randomized traffic against the reference model.
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int v = 0; v < NV; v++) begin
                if (!req[v] && $urandom_range(3) == 0) begin
                    req[v] = 1'b1;
                    x[v*16 +: 16] = 16'($urandom);
                end
            end
            Enable    = ($urandom_range(7) != 0);
            cfg_we    = ($urandom_range(9) == 0);
            cfg_voice = 2'($urandom);
            cfg_sel   = 3'($urandom);
            cfg_data  = 16'($urandom);
            @(negedge Clk);
            model_step();
            g = gnt;
            @(posedge Clk); #1;
            req = req & ~g;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule

// File: doc/biquad_voice_sched.md
BIQUAD_VOICE_SCHED -- requirements
Module: biquad_voice_sched

Interface
REQ-001 Parameter: NVOICE, 4, number of voice requesters sharing one biquad datapath (power of two, 2..8).
REQ-002 Parameter: W, 16, sample/coefficient width; products are 2W bits.
REQ-003 Clk  in  1  single clock; all state updates on posedge Clk.
REQ-004 Reset  in  1  synchronous, active-high reset.
REQ-005 Enable  in  1  high permits new grants; low blocks grants, and any in-flight sample completes.
REQ-006 req  in  NVOICE  per-voice sample request; held high with x stable until gnt.
REQ-007 x  in  NVOICE*W  packed per-voice input samples; voice v at [v*W +: W].
REQ-008 cfg_we  in  1  coefficient write strobe.
REQ-009 cfg_voice  in  clog2(NVOICE)  coefficient target voice.
REQ-010 cfg_sel  in  3  coefficient select: 0=a0,1=a1,2=a2,3=b0,4=b1,5=b2; 6,7 ignored.
REQ-011 cfg_data  in  W  coefficient value.
REQ-012 gnt  out  NVOICE  one-hot, one-cycle pulse; the sample of the granted voice is captured that cycle.
REQ-013 y  out  W  filtered output sample.
REQ-014 y_valid  out  1  one-cycle pulse qualifying y and y_voice.
REQ-015 y_voice  out  clog2(NVOICE)  voice index of y.
REQ-016 busy  out  1  high from grant cycle through y_valid cycle.

Function
REQ-017 FSM states: IDLE, MAC, SCALE, DONE; IDLE->MAC on grant; MAC runs steps 0..4; MAC->SCALE after step 4; SCALE->DONE; DONE->IDLE, or DONE->MAC directly when a grant issues in the DONE cycle.
REQ-018 Grant issues only in IDLE or DONE, with Enable=1 and at least one req bit set; round-robin search starts at the voice after the last granted; the pointer is voice 0 after reset.
REQ-019 At grant: capture x[v]; snapshot voice v's six coefficients and its history x1,x2,y1,y2.
REQ-020 Term product: unsigned W x W -> 2W; the term value is bits [2W-1:W].
REQ-021 MAC steps 0..4 accumulate b0*x, b1*x1, b2*x2, a1*y1, a2*y2 into a W-bit accumulator cleared at grant; additions wrap modulo 2^W with no saturation.
REQ-022 SCALE: y = upper W bits of a0*acc.
REQ-023 Latency: gnt in cycle T gives y_valid in cycle T+7; the next grant can issue in T+7, so peak throughput is one sample per 7 cycles.
REQ-024 On the y_valid edge, voice v's history updates as x2<=x1, x1<=x, y2<=y1, y1<=y; the other voices' history is untouched.
REQ-025 y and y_voice hold their values until the next y_valid.
REQ-026 A cfg write takes effect on the next edge; a write to the in-flight voice does not alter the current computation and applies from the next grant.
REQ-027 Enable falling mid-computation: the computation completes and y_valid fires; no further grant issues until Enable=1.
REQ-028 A req for the in-flight voice, or for any voice while busy, waits; requests are never dropped.

Reset
REQ-029 Reset zeroes all history, the accumulator, y, y_voice, gnt, y_valid and busy, sets the FSM to IDLE and the RR pointer to voice 0.
REQ-030 Reset loads every voice with a0=b0=16'hFFFF and all other coefficients 0.
REQ-031 Reset asserted mid-computation aborts it: no y_valid and no history update.

Structure
REQ-032 Shared package filter_pkg holds W, the coefficient-select enum (A0..B2) and the FSM state enum.
REQ-033 Exactly one sub-module, q16_mul (unsigned W x W, returns the upper W bits), instantiated once and shared by all steps.

Verification
REQ-034 Reset defaults; voice 0 with x=16'h8000 -> gnt[0] at T, y_valid at T+7, y=16'h7FFE, y_voice=0.
REQ-035 All req high from cycle 0 -> gnt order 0,1,2,3 at T, T+7, T+14, T+21.
REQ-036 Voice 2 configured b0=0, b1=16'h8000, a0=16'hFFFF; x=16'h4000 then x=0 -> y=0, then y=16'h1FFF.
REQ-037 Reset pulsed at T+3 of a computation -> no y_valid, busy=0 next cycle, history of that voice zero.
REQ-038 Enable=0 with req[1] high for 20 cycles -> no gnt; Enable=1 -> gnt[1] in the same cycle.
REQ-039 cfg write b0=0 to voice 0 at T+2 of a voice-0 computation -> current y unaffected (16'h7FFE for x=16'h8000); the next voice-0 sample gives y=0.
